// File: rtl/riscv_test_status.sv
// Memory-mapped tohost responder: decodes riscv-tests pass/fail writes, runs a cycle
// watchdog and exposes registered done/passed/timeout flags plus a readable status word.
module riscv_test_status #(
    parameter logic [31:0] TOHOST_ADDR    = 32'h0000_1000,
    parameter logic [31:0] STATUS_ADDR    = 32'h0000_1004,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] bus_addr,
    input  logic        bus_we,
    input  logic        bus_re,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        done,
    output logic        passed,
    output logic        timeout,
    output logic [30:0] fail_test,
    output logic [31:0] cycle_count
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PASS    = 2'd1;
    localparam logic [1:0] ST_FAIL    = 2'd2;
    localparam logic [1:0] ST_TIMEOUT = 2'd3;

    localparam logic [31:0] LAST_CYCLE = 32'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [31:0] tohost_q, tohost_d;
    logic [31:0] count_d;
    logic [30:0] fail_d;
    logic [31:0] rdata_d;
    logic        hit_tohost, hit_status, hit, tohost_wr;

    assign hit_tohost = (bus_addr == TOHOST_ADDR);
    assign hit_status = (bus_addr == STATUS_ADDR);
    assign hit        = (hit_tohost || hit_status) && (bus_we || bus_re);
    // Only writes seen while still running can update tohost or decide the outcome.
    assign tohost_wr  = bus_we && hit_tohost && (state_q == ST_RUN);

    always_comb begin
        state_d  = state_q;
        tohost_d = tohost_q;
        count_d  = cycle_count;
        fail_d   = fail_test;
        if (state_q == ST_RUN) begin
            if (tohost_wr) begin
                tohost_d = bus_wdata;
            end
            if (tohost_wr && bus_wdata == 32'd1) begin
                state_d = ST_PASS;
            end else if (tohost_wr && bus_wdata[0]) begin
                state_d = ST_FAIL;
                fail_d  = bus_wdata[31:1];
            end else if (cycle_count == LAST_CYCLE) begin
                state_d = ST_TIMEOUT;
            end
            // Expiry freezes the count at the limit-1 value it was reached with.
            if (state_d != ST_TIMEOUT) begin
                count_d = cycle_count + 32'd1;
            end
        end
    end

    always_comb begin
        rdata_d = 32'd0;
        if (hit && !bus_we) begin
            if (hit_tohost) begin
                rdata_d = tohost_q;
            end else begin
                rdata_d = {cycle_count[29:0], state_q};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            tohost_q    <= 32'd0;
            cycle_count <= 32'd0;
            fail_test   <= 31'd0;
            bus_ack     <= 1'b0;
            bus_rdata   <= 32'd0;
            done        <= 1'b0;
            passed      <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state_q     <= state_d;
            tohost_q    <= tohost_d;
            cycle_count <= count_d;
            fail_test   <= fail_d;
            bus_ack     <= hit;
            bus_rdata   <= rdata_d;
            done        <= (state_d != ST_RUN);
            passed      <= (state_d == ST_PASS);
            timeout     <= (state_d == ST_TIMEOUT);
        end
    end

endmodule

// File: tb/tb_riscv_test_status.sv
// Scoreboarded bench for riscv_test_status: default-timeout and short-timeout instances.
module tb_riscv_test_status;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default watchdog
    logic        rst_a, we_a, re_a, ack_a, done_a, passed_a, to_a;
    logic [31:0] addr_a, wdata_a, rdata_a, cnt_a;
    logic [30:0] ft_a;
    // Instance B: 64-cycle watchdog
    logic        rst_b, we_b, re_b, ack_b, done_b, passed_b, to_b;
    logic [31:0] addr_b, wdata_b, rdata_b, cnt_b;
    logic [30:0] ft_b;

    riscv_test_status dut_a (
        .clk(clk), .rst(rst_a), .bus_addr(addr_a), .bus_we(we_a), .bus_re(re_a),
        .bus_wdata(wdata_a), .bus_rdata(rdata_a), .bus_ack(ack_a), .done(done_a),
        .passed(passed_a), .timeout(to_a), .fail_test(ft_a), .cycle_count(cnt_a)
    );

    riscv_test_status #(.TIMEOUT_CYCLES(64)) dut_b (
        .clk(clk), .rst(rst_b), .bus_addr(addr_b), .bus_we(we_b), .bus_re(re_b),
        .bus_wdata(wdata_b), .bus_rdata(rdata_b), .bus_ack(ack_b), .done(done_b),
        .passed(passed_b), .timeout(to_b), .fail_test(ft_b), .cycle_count(cnt_b)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Entries are {mask, expected rdata}
    logic [63:0] qa[$];
    logic [63:0] qb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (ack_a === 1'b1) begin
            if (qa.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL a_unexpected_ack: got ack=1 expected ack=0");
            end else begin
                logic [63:0] e;
                e = qa.pop_front();
                chk("a_rdata", 64'(rdata_a & e[63:32]), 64'(e[31:0]));
            end
        end
    end

    always @(negedge clk) begin
        if (ack_b === 1'b1) begin
            if (qb.size() == 0) begin
                n_cmp++; n_err++;
                $display("FAIL b_unexpected_ack: got ack=1 expected ack=0");
            end else begin
                logic [63:0] e;
                e = qb.pop_front();
                chk("b_rdata", 64'(rdata_b & e[63:32]), 64'(e[31:0]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle access on A; expect an ack carrying exp (masked) unless expect_ack is 0.
    task automatic acc_a(input logic [31:0] a, input logic w, input logic r,
                         input logic [31:0] d, input logic expect_ack,
                         input logic [31:0] exp, input logic [31:0] mask);
        addr_a = a; we_a = w; re_a = r; wdata_a = d;
        if (expect_ack) qa.push_back({mask, exp});
        step();
        we_a = 1'b0; re_a = 1'b0; addr_a = 32'd0; wdata_a = 32'd0;
    endtask

    task automatic acc_b(input logic [31:0] a, input logic w, input logic r,
                         input logic [31:0] d, input logic [31:0] exp);
        addr_b = a; we_b = w; re_b = r; wdata_b = d;
        qb.push_back({32'hFFFF_FFFF, exp});
        step();
        we_b = 1'b0; re_b = 1'b0; addr_b = 32'd0; wdata_b = 32'd0;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        step();
        step();
        rst_a = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench exceeded time limit");
        $fatal(1, "time limit");
    end

    initial begin
        rst_a = 1'b1; we_a = 0; re_a = 0; addr_a = 0; wdata_a = 0;
        rst_b = 1'b1; we_b = 0; re_b = 0; addr_b = 0; wdata_b = 0;
        step();
        step();
        chk("rst_done",   64'(done_a), 64'd0);
        chk("rst_passed", 64'(passed_a), 64'd0);
        chk("rst_timeout", 64'(to_a), 64'd0);
        chk("rst_ack",    64'(ack_a), 64'd0);
        chk("rst_rdata",  64'(rdata_a), 64'd0);
        chk("rst_count",  64'(cnt_a), 64'd0);
        chk("rst_fail",   64'(ft_a), 64'd0);

        // 1: pass at RUN cycle 100
        rst_a = 1'b0;
        repeat (100) step();
        chk("t1_count100", 64'(cnt_a), 64'd100);
        acc_a(32'h1000, 1, 0, 32'h1, 1, 32'h0, 32'hFFFF_FFFF);
        chk("t1_done",   64'(done_a), 64'd1);
        chk("t1_passed", 64'(passed_a), 64'd1);
        chk("t1_fail",   64'(ft_a), 64'd0);
        chk("t1_timeout", 64'(to_a), 64'd0);
        repeat (5) step();
        chk("t1_frozen", 64'(cnt_a), 64'd101);
        acc_a(32'h1004, 0, 1, 0, 1, (32'd101 << 2) | 32'd1, 32'hFFFF_FFFF);
        acc_a(32'h1000, 0, 1, 0, 1, 32'h1, 32'hFFFF_FFFF);
        step();

        // 6: reset one cycle after PASS
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        chk("t6_done",  64'(done_a), 64'd0);
        chk("t6_passed", 64'(passed_a), 64'd0);
        chk("t6_count", 64'(cnt_a), 64'd0);
        step();
        chk("t6_count1", 64'(cnt_a), 64'd1);

        // 2: fail with test number 3, later pass write ignored
        acc_a(32'h1000, 1, 0, 32'h7, 1, 32'h0, 32'hFFFF_FFFF);
        chk("t2_done",   64'(done_a), 64'd1);
        chk("t2_passed", 64'(passed_a), 64'd0);
        chk("t2_fail",   64'(ft_a), 64'd3);
        acc_a(32'h1000, 1, 0, 32'h1, 1, 32'h0, 32'hFFFF_FFFF);
        chk("t2_still_fail", 64'(passed_a), 64'd0);
        acc_a(32'h1000, 0, 1, 0, 1, 32'h7, 32'hFFFF_FFFF);
        acc_a(32'h1004, 0, 1, 0, 1, 32'd2, 32'h3);
        step();

        // 5: clear, syscall value, reads, decode miss
        reset_a();
        acc_a(32'h1000, 1, 0, 32'h0, 1, 32'h0, 32'hFFFF_FFFF);
        acc_a(32'h1000, 1, 0, 32'h2, 1, 32'h0, 32'hFFFF_FFFF);
        acc_a(32'h1000, 0, 1, 0, 1, 32'h2, 32'hFFFF_FFFF);
        chk("t5_done", 64'(done_a), 64'd0);
        acc_a(32'h1004, 0, 1, 0, 1, 32'd0, 32'h3);
        acc_a(32'h2000, 1, 0, 32'h1, 0, 0, 0);
        chk("t5_miss_ack", 64'(ack_a), 64'd0);
        chk("t5_miss_done", 64'(done_a), 64'd0);
        // we and re together on tohost act as a write
        acc_a(32'h1000, 1, 1, 32'h1, 1, 32'h0, 32'hFFFF_FFFF);
        chk("t5_we_re_pass", 64'(passed_a), 64'd1);
        step();

        // 3: watchdog expiry on B
        rst_b = 1'b0;
        repeat (63) step();
        chk("t3_pre_done", 64'(done_b), 64'd0);
        chk("t3_pre_count", 64'(cnt_b), 64'd63);
        step();
        chk("t3_done",    64'(done_b), 64'd1);
        chk("t3_timeout", 64'(to_b), 64'd1);
        chk("t3_passed",  64'(passed_b), 64'd0);
        repeat (3) step();
        chk("t3_count", 64'(cnt_b), 64'd63);
        acc_b(32'h1004, 0, 1, 0, 32'h0000_00FF);
        step();

        // 4: pass write on the expiring edge wins
        rst_b = 1'b1;
        step();
        rst_b = 1'b0;
        repeat (63) step();
        acc_b(32'h1000, 1, 0, 32'h1, 32'h0);
        chk("t4_passed",  64'(passed_b), 64'd1);
        chk("t4_timeout", 64'(to_b), 64'd0);
        chk("t4_done",    64'(done_b), 64'd1);
        repeat (3) step();

        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
